// File: rtl/bus_ctrl_if.sv
// Bus bundle between the CPU port, the memory-map decoder and the peripheral slots.
// master: the bus_ctrl sequencer. slave: the CPU, decoder and modules around it.
interface bus_ctrl_if #(
   parameter int unsigned NMOD = 12
);
   logic                   cpu_req;
   logic                   cpu_we;
   logic [31:0]            cpu_addr;
   logic [31:0]            cpu_wdata;
   logic [31:0]            cpu_rdata;
   logic                   cpu_ack;
   logic                   cpu_err;
   logic                   stall;
   logic [31:0]            mm_addr;
   logic [7:0]             mm_mod;
   logic [31:0]            mm_eff_addr;
   logic [NMOD-1:0]        mod_sel;
   logic                   mod_we;
   logic [31:0]            mod_addr;
   logic [31:0]            mod_wdata;
   logic [NMOD*32-1:0]     mod_rdata;
   logic [NMOD-1:0]        mod_ready;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mm_mod, mm_eff_addr, mod_rdata, mod_ready,
      output cpu_rdata, cpu_ack, cpu_err, stall, mm_addr, mod_sel, mod_we, mod_addr, mod_wdata
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mm_mod, mm_eff_addr, mod_rdata, mod_ready,
      input  cpu_rdata, cpu_ack, cpu_err, stall, mm_addr, mod_sel, mod_we, mod_addr, mod_wdata
   );
endinterface

// File: rtl/bus_ctrl.sv
// Bus sequencer: latches a CPU request, decodes it through the memory map, drives the
// addressed module slot and returns data/ack (or a bus error) to the CPU.
module bus_ctrl #(
   parameter int unsigned NMOD    = 12,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst,
   bus_ctrl_if.master   bus
);

   localparam int unsigned IdW = (NMOD > 1) ? $clog2(NMOD) : 1;

   typedef enum logic [2:0] {StIdle, StDecode, StWait, StDone, StErr} state_e;

   state_e            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [IdW-1:0]    mod_id_q, mod_id_d;
   logic [NMOD-1:0]   mod_sel_q, mod_sel_d;
   logic              mod_we_q, mod_we_d;
   logic [31:0]       mod_addr_q, mod_addr_d;
   logic [31:0]       mod_wdata_q, mod_wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [7:0]        cnt_q, cnt_d;

   logic              dec_err;
   logic              sel_ready;
   logic [31:0]       sel_rdata;

   // Decode fault: misaligned, slot out of range, or decoder fell through to its default.
   assign dec_err = (addr_q[1:0] != 2'b00) ||
                    (bus.mm_mod >= 8'(NMOD)) ||
                    ((bus.mm_mod == 8'd0) && (addr_q[31:20] != 12'h000));

   // Pick ready and read data of the latched slot only; other slots are ignored.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = 32'h0;
      for (int i = 0; i < int'(NMOD); i++) begin
         if (mod_id_q == IdW'(i)) begin
            sel_ready = bus.mod_ready[i];
            sel_rdata = bus.mod_rdata[32*i +: 32];
         end
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      mod_id_d    = mod_id_q;
      mod_sel_d   = mod_sel_q;
      mod_we_d    = mod_we_q;
      mod_addr_d  = mod_addr_q;
      mod_wdata_d = mod_wdata_q;
      rdata_d     = rdata_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = 8'd0;
            if (bus.cpu_req) begin
               addr_d  = bus.cpu_addr;
               we_d    = bus.cpu_we;
               wdata_d = bus.cpu_wdata;
               state_d = StDecode;
            end
         end
         StDecode: begin
            mod_id_d   = bus.mm_mod[IdW-1:0];
            mod_addr_d = bus.mm_eff_addr;
            if (dec_err) begin
               rdata_d = 32'h0;
               state_d = StErr;
            end else begin
               mod_sel_d   = NMOD'(1) << bus.mm_mod[IdW-1:0];
               mod_we_d    = we_q;
               mod_wdata_d = wdata_q;
               state_d     = StWait;
            end
         end
         StWait: begin
            if (sel_ready) begin
               if (!we_q) begin
                  rdata_d = sel_rdata;
               end
               mod_sel_d = '0;
               mod_we_d  = 1'b0;
               state_d   = StDone;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == 8'(TIMEOUT)) begin
                  mod_sel_d = '0;
                  mod_we_d  = 1'b0;
                  rdata_d   = 32'h0;
                  state_d   = StErr;
               end
            end
         end
         StDone: begin
            cnt_d   = 8'd0;
            state_d = StIdle;
         end
         StErr: begin
            cnt_d   = 8'd0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset drops every select immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         addr_q      <= 32'h0;
         we_q        <= 1'b0;
         wdata_q     <= 32'h0;
         mod_id_q    <= '0;
         mod_sel_q   <= '0;
         mod_we_q    <= 1'b0;
         mod_addr_q  <= 32'h0;
         mod_wdata_q <= 32'h0;
         rdata_q     <= 32'h0;
         cnt_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         mod_id_q    <= mod_id_d;
         mod_sel_q   <= mod_sel_d;
         mod_we_q    <= mod_we_d;
         mod_addr_q  <= mod_addr_d;
         mod_wdata_q <= mod_wdata_d;
         rdata_q     <= rdata_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.mm_addr   = addr_q;
   assign bus.mod_sel   = mod_sel_q;
   assign bus.mod_we    = mod_we_q;
   assign bus.mod_addr  = mod_addr_q;
   assign bus.mod_wdata = mod_wdata_q;
   assign bus.cpu_rdata = rdata_q;
   assign bus.cpu_ack   = (state_q == StDone) || (state_q == StErr);
   assign bus.cpu_err   = (state_q == StErr);
   // Stall is gated by reset so it falls together with the selects.
   assign bus.stall     = rst & ((state_q == StDecode) || (state_q == StWait) ||
                                 ((state_q == StIdle) && bus.cpu_req));

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: table of single transactions plus hand-written
// reset-mid-WAIT and back-to-back sequences.
module tb_bus_ctrl;
   localparam int unsigned NMOD = 12;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   bus_ctrl_if #(.NMOD(NMOD)) bus ();

   bus_ctrl #(.NMOD(NMOD), .TIMEOUT(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] slot_data [NMOD];

   // Memory-map decoder model: top nibble picks the slot, rest is the effective address.
   always_comb begin
      bus.mm_mod      = 8'd0;
      bus.mm_eff_addr = bus.mm_addr;
      case (bus.mm_addr[31:28])
         4'h1: begin bus.mm_mod = 8'd1;  bus.mm_eff_addr = {4'h0, bus.mm_addr[27:0]}; end
         4'h2: begin bus.mm_mod = 8'd2;  bus.mm_eff_addr = {4'h0, bus.mm_addr[27:0]}; end
         4'h8: begin bus.mm_mod = 8'd8;  bus.mm_eff_addr = {4'h0, bus.mm_addr[27:0]}; end
         4'hD: begin bus.mm_mod = 8'd13; bus.mm_eff_addr = {4'h0, bus.mm_addr[27:0]}; end
         4'hF: begin
            if (bus.mm_addr[31:20] == 12'hF02) begin
               bus.mm_mod      = 8'd5;
               bus.mm_eff_addr = {12'h0, bus.mm_addr[19:0]};
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.mod_rdata = '0;
      for (int i = 0; i < int'(NMOD); i++) bus.mod_rdata[32*i +: 32] = slot_data[i];
   end

   typedef struct {
      logic            we;
      logic [31:0]     addr;
      logic [31:0]     wdata;
      int              rdy_wait;    // WAIT cycle on which the slot readies; 0 = never
      logic [NMOD-1:0] exp_sel;
      logic [31:0]     exp_maddr;
      int              exp_ack_cyc; // cycles after the accepting edge
      logic            exp_err;
      logic [31:0]     exp_rdata;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One complete transaction; non-selected slots report ready while the real one waits.
   task automatic run_vec(input vec_t v, input string name);
      int              cyc;
      int              waits;
      int              ack_cyc;
      logic [NMOD-1:0] sel_or;
      logic            stall_ok;
      logic            attr_ok;
      logic            err_seen;
      logic [31:0]     rdata_seen;
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = v.we;
      bus.cpu_addr  = v.addr;
      bus.cpu_wdata = v.wdata;
      #1;
      stall_ok   = (bus.stall === 1'b1);
      attr_ok    = 1'b1;
      cyc        = 0;
      waits      = 0;
      ack_cyc    = -1;
      sel_or     = '0;
      err_seen   = 1'b0;
      rdata_seen = 32'h0;
      while (ack_cyc < 0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         bus.mod_ready = '0;
         if (cyc == 1) begin
            bus.cpu_addr  = ~v.addr;
            bus.cpu_wdata = ~v.wdata;
            bus.cpu_we    = ~v.we;
         end
         if (bus.cpu_ack === 1'b1) begin
            ack_cyc    = cyc;
            err_seen   = bus.cpu_err;
            rdata_seen = bus.cpu_rdata;
            if (bus.stall !== 1'b0) stall_ok = 1'b0;
         end else begin
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            if (bus.mod_sel != '0) begin
               waits++;
               sel_or = sel_or | bus.mod_sel;
               if (bus.mod_addr !== v.exp_maddr || bus.mod_we !== v.we ||
                   (v.we && bus.mod_wdata !== v.wdata)) attr_ok = 1'b0;
               bus.mod_ready = (waits == v.rdy_wait) ? '1 : ~v.exp_sel;
            end
         end
      end
      bus.mod_ready = '0;
      bus.cpu_req   = 1'b0;
      check({name, "_ack_cycle"}, 32'(ack_cyc), 32'(v.exp_ack_cyc));
      check({name, "_err"}, 32'(err_seen), 32'(v.exp_err));
      check({name, "_rdata"}, rdata_seen, v.exp_rdata);
      check({name, "_sel"}, 32'(sel_or), 32'(v.exp_sel));
      check({name, "_mod_attrs"}, 32'(attr_ok), 32'd1);
      check({name, "_stall"}, 32'(stall_ok), 32'd1);
      @(negedge clk);
      check({name, "_pulse_len"}, {30'h0, bus.cpu_ack, bus.cpu_err}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   a1;
      int   a2;
      int   waits;
      logic gap_stall;
      logic gap_ack;
      logic [31:0] rd2;
      vec_t led;

      slot_data[0]  = 32'hDEADBEEF;
      slot_data[1]  = 32'h0BADF00D;
      slot_data[2]  = 32'hA5A55A5A;
      slot_data[5]  = 32'hC0FFEE00;
      slot_data[8]  = 32'h11112222;
      foreach (slot_data[i]) if (i inside {3, 4, 6, 7, 9, 10, 11}) slot_data[i] = 32'h5000_0000 + i;

      //          we    addr          wdata         rdy sel       maddr        ack err rdata
      vecs[0] = '{1'b0, 32'h00000010, 32'h0,        1, 12'h001, 32'h00000010, 3,  1'b0, 32'hDEADBEEF};
      vecs[1] = '{1'b1, 32'h10000040, 32'h12345678, 4, 12'h002, 32'h00000040, 6,  1'b0, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 32'hE0000000, 32'h0,        0, 12'h000, 32'h0,        2,  1'b1, 32'h0};
      vecs[3] = '{1'b0, 32'hF0200002, 32'h0,        0, 12'h000, 32'h0,        2,  1'b1, 32'h0};
      vecs[4] = '{1'b0, 32'h20000008, 32'h0,        3, 12'h004, 32'h00000008, 5,  1'b0, 32'hA5A55A5A};
      vecs[5] = '{1'b0, 32'hD0000000, 32'h0,        0, 12'h000, 32'h0,        2,  1'b1, 32'h0};
      vecs[6] = '{1'b0, 32'h80000010, 32'h0,        0, 12'h100, 32'h00000010, 257, 1'b1, 32'h0};
      vecs[7] = '{1'b0, 32'h10000040, 32'h0,        2, 12'h002, 32'h00000040, 4,  1'b0, 32'h0BADF00D};
      vecs[8] = '{1'b1, 32'hF0200000, 32'hCAFEF00D, 1, 12'h020, 32'h0,        3,  1'b0, 32'h0BADF00D};
      led     = '{1'b1, 32'hF0200000, 32'h600DF00D, 2, 12'h020, 32'h0,        4,  1'b0, 32'h0};

      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 32'h0;
      bus.cpu_wdata = 32'h0;
      bus.mod_ready = '0;

      // Reset state.
      #12;
      check("rst_rdata", bus.cpu_rdata, 32'h0);
      check("rst_ack_err_stall", {29'h0, bus.cpu_ack, bus.cpu_err, bus.stall}, 32'h0);
      check("rst_mod_sel_we", {19'h0, bus.mod_sel, bus.mod_we}, 32'h0);
      check("rst_mod_addr", bus.mod_addr, 32'h0);
      check("rst_mod_wdata", bus.mod_wdata, 32'h0);
      check("rst_mm_addr", bus.mm_addr, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

      // Reset in the middle of a UART access.
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h20000000;
      for (int c = 0; c < 10 && bus.mod_sel == '0; c++) @(negedge clk);
      check("rstw_sel_before", 32'(bus.mod_sel), 32'h004);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rstw_sel", 32'(bus.mod_sel), 32'h0);
      check("rstw_stall_ack", {30'h0, bus.stall, bus.cpu_ack}, 32'h0);
      check("rstw_rdata", bus.cpu_rdata, 32'h0);
      bus.cpu_req = 1'b0;
      @(negedge clk);
      check("rstw_no_ack", 32'(bus.cpu_ack), 32'h0);
      rst = 1'b1;
      run_vec(led, "led_after_rst");

      // Back-to-back reads with cpu_req held across the ack.
      @(negedge clk);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h00000020;
      a1 = -1;
      a2 = -1;
      waits = 0;
      gap_stall = 1'b0;
      gap_ack   = 1'b1;
      rd2 = 32'h0;
      for (int c = 1; c <= 30 && a2 < 0; c++) begin
         @(negedge clk);
         bus.mod_ready = '0;
         if (a1 > 0 && c == a1 + 1) begin
            gap_stall = bus.stall;
            gap_ack   = bus.cpu_ack;
         end
         if (bus.cpu_ack === 1'b1) begin
            if (a1 < 0) begin
               a1 = c;
               bus.cpu_addr = 32'h00000024;
               waits = 0;
            end else begin
               a2  = c;
               rd2 = bus.cpu_rdata;
            end
         end else if (bus.mod_sel != '0) begin
            waits++;
            bus.mod_ready = (waits == 1) ? 12'hFFE : 12'hFFF;
         end
      end
      bus.cpu_req   = 1'b0;
      bus.mod_ready = '0;
      check("b2b_ack1_cycle", 32'(a1), 32'd4);
      check("b2b_ack2_cycle", 32'(a2), 32'd9);
      check("b2b_gap_idle", {30'h0, gap_stall, gap_ack}, 32'h2);
      check("b2b_rdata2", rd2, 32'hDEADBEEF);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
